// File: rtl/pc_branch_ctrl.sv
// rtl/pc_branch_ctrl.sv - X9 program counter, condition flag/carry and start/halt sequencer
// Branches resolve against the registered flag through a writable target LUT.
module pc_branch_ctrl #(
  parameter int PC_W       = 10,
  parameter int LUT_AW     = 4,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              flag_we,
  input  logic              one_i,
  input  logic              sc_we,
  input  logic              sc_i,
  input  logic              br_t,
  input  logic              br_ne,
  input  logic [LUT_AW-1:0] lut_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              flag_q,
  output logic              sc_q,
  output logic              running,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam int              LUT_N    = 1 << LUT_AW;
  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              cond_q, cond_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              done_q, done_d;
  logic [PC_W-1:0]   lut_q [LUT_N];
  logic              br_take;

  // Branch decision uses the flag as it stood before this instruction's compare.
  assign br_take = (br_t && cond_q) || (br_ne && !cond_q);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cond_d  = cond_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!stall) begin
          if (flag_we) cond_d  = one_i;
          if (sc_we)   carry_d = sc_i;
          if (halt_req) begin
            state_d = S_HALT;
          end else if (br_take) begin
            pc_d = lut_q[lut_idx];
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
          cond_d  = 1'b0;
          carry_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    run_d  = (state_d == S_RUN);
    done_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      cond_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < LUT_N; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cond_q  <= cond_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      done_q  <= done_d;
      // Reads above see the pre-edge entry, so a same-cycle read returns old data.
      if (lut_we) begin
        lut_q[lut_waddr] <= lut_wdata;
      end
    end
  end

  assign pc        = pc_q;
  assign flag_q    = cond_q;
  assign sc_q      = carry_q;
  assign running   = run_q;
  assign done      = done_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb/tb_pc_branch_ctrl.sv - directed vector table plus randomized run against a behavioural model
module tb_pc_branch_ctrl;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic reset, start, stall, halt_req, flag_we, one_i, sc_we, sc_i, br_t, br_ne, lut_we;
  logic [LUT_AW-1:0] lut_idx, lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc, pc4;
  logic              flag_q, sc_q, running, done;
  logic              flag_q4, sc_q4, running4, done4;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [3:0]        cycle_cnt4;

  always #5 clk = ~clk;

  pc_branch_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW), .START_ADDR(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .flag_we(flag_we), .one_i(one_i), .sc_we(sc_we), .sc_i(sc_i), .br_t(br_t), .br_ne(br_ne),
    .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc(pc), .flag_q(flag_q), .sc_q(sc_q), .running(running), .done(done), .cycle_cnt(cycle_cnt)
  );

  pc_branch_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW), .START_ADDR(0), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .flag_we(flag_we), .one_i(one_i), .sc_we(sc_we), .sc_i(sc_i), .br_t(br_t), .br_ne(br_ne),
    .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc(pc4), .flag_q(flag_q4), .sc_q(sc_q4), .running(running4), .done(done4), .cycle_cnt(cycle_cnt4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle, 1=run, 2=halt; counter kept unsaturated.
  int m_mode, m_pc, m_flag, m_sc, m_cnt;
  int m_lut [16];

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_flag = 0; m_sc = 0; m_cnt = 0;
    for (int i = 0; i < 16; i++) m_lut[i] = 0;
  endtask

  task automatic model_step();
    int tgt;
    tgt = m_lut[lut_idx];
    if (m_mode == 1) begin
      m_cnt++;
      if (!stall) begin
        if (halt_req) m_mode = 2;
        else if ((br_t && m_flag == 1) || (br_ne && m_flag == 0)) m_pc = tgt;
        else m_pc = (m_pc + 1) % 1024;
        if (flag_we) m_flag = int'(one_i);
        if (sc_we)   m_sc   = int'(sc_i);
      end
    end else if (start) begin
      if (m_mode == 2) begin
        m_flag = 0;
        m_sc   = 0;
      end
      m_mode = 1;
      m_pc   = 0;
      m_cnt  = 0;
    end
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},      int'(pc),         m_pc);
    chk({tag, ".flag"},    int'(flag_q),     m_flag);
    chk({tag, ".sc"},      int'(sc_q),       m_sc);
    chk({tag, ".running"}, int'(running),    (m_mode == 1) ? 1 : 0);
    chk({tag, ".done"},    int'(done),       (m_mode == 2) ? 1 : 0);
    chk({tag, ".cnt"},     int'(cycle_cnt),  (m_cnt > 65535) ? 65535 : m_cnt);
    chk({tag, ".cnt4"},    int'(cycle_cnt4), (m_cnt > 15) ? 15 : m_cnt);
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; halt_req = 0; flag_we = 0; one_i = 0; sc_we = 0; sc_i = 0;
    br_t = 0; br_ne = 0; lut_idx = 0; lut_we = 0; lut_waddr = 0; lut_wdata = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic st, stl, hlt, fwe, one, swe, sc, bt, bne;
    logic [3:0] idx;
    logic       lwe;
    logic [3:0] lwa;
    logic [9:0] lwd;
    int e_pc, e_flag, e_sc, e_run, e_done, e_cnt;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic st, stl, hlt, fwe, one, swe, sc, bt, bne,
                              input int idx, input logic lwe, input int lwa, input int lwd,
                              input int e_pc, e_flag, e_sc, e_run, e_done, e_cnt);
    vec_t v;
    v.st = st; v.stl = stl; v.hlt = hlt; v.fwe = fwe; v.one = one; v.swe = swe; v.sc = sc;
    v.bt = bt; v.bne = bne; v.idx = 4'(idx); v.lwe = lwe; v.lwa = 4'(lwa); v.lwd = 10'(lwd);
    v.e_pc = e_pc; v.e_flag = e_flag; v.e_sc = e_sc; v.e_run = e_run; v.e_done = e_done;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    //           st stl hlt fwe one swe sc bt bne idx lwe lwa lwd      pc    f  s  r  d  cnt
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 5, 'h040,  'h000, 0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,      'h001, 0, 0, 1, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,      'h002, 0, 0, 1, 0, 2);
    tbl[3]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0,      'h003, 1, 0, 1, 0, 3);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5,  0, 0, 0,      'h040, 1, 0, 1, 0, 4);
    tbl[5]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,      'h041, 0, 0, 1, 0, 5);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5,  0, 0, 0,      'h042, 0, 0, 1, 0, 6);
    tbl[7]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 5,  0, 0, 0,      'h040, 1, 0, 1, 0, 7);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 6,  1, 6, 'h3FF,  'h000, 1, 0, 1, 0, 8);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 6,  0, 0, 0,      'h3FF, 1, 0, 1, 0, 9);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,      'h000, 1, 0, 1, 0, 10);
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0,      'h001, 1, 1, 1, 0, 11);
    tbl[12] = mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 5,  0, 0, 0,      'h001, 1, 1, 1, 0, 12);
    tbl[13] = mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 5,  0, 0, 0,      'h001, 1, 1, 1, 0, 13);
    tbl[14] = mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 5,  0, 0, 0,      'h001, 1, 1, 1, 0, 14);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 5,  0, 0, 0,      'h040, 1, 1, 1, 0, 15);
    tbl[16] = mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 6,  0, 0, 0,      'h040, 0, 1, 0, 1, 16);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,      'h040, 0, 1, 0, 1, 16);
    tbl[18] = mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0,      'h040, 0, 1, 0, 1, 16);
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,      'h000, 0, 0, 1, 0, 0);
    tbl[20] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,      'h001, 0, 0, 1, 0, 1);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 6,  0, 0, 0,      'h3FF, 0, 0, 1, 0, 2);

    idle_inputs();
    reset = 1'b1;
    #3;
    chk("rst.pc", int'(pc), 0);
    chk("rst.flag", int'(flag_q), 0);
    chk("rst.sc", int'(sc_q), 0);
    chk("rst.running", int'(running), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.cnt", int'(cycle_cnt), 0);
    #9 reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    for (int r = 0; r < 22; r++) begin
      start = tbl[r].st; stall = tbl[r].stl; halt_req = tbl[r].hlt;
      flag_we = tbl[r].fwe; one_i = tbl[r].one; sc_we = tbl[r].swe; sc_i = tbl[r].sc;
      br_t = tbl[r].bt; br_ne = tbl[r].bne; lut_idx = tbl[r].idx;
      lut_we = tbl[r].lwe; lut_waddr = tbl[r].lwa; lut_wdata = tbl[r].lwd;
      tick();
      chk($sformatf("vec%0d.pc", r),      int'(pc),        tbl[r].e_pc);
      chk($sformatf("vec%0d.flag", r),    int'(flag_q),    tbl[r].e_flag);
      chk($sformatf("vec%0d.sc", r),      int'(sc_q),      tbl[r].e_sc);
      chk($sformatf("vec%0d.running", r), int'(running),   tbl[r].e_run);
      chk($sformatf("vec%0d.done", r),    int'(done),      tbl[r].e_done);
      chk($sformatf("vec%0d.cnt", r),     int'(cycle_cnt), tbl[r].e_cnt);
      chk($sformatf("vec%0d.cnt4", r),    int'(cycle_cnt4), (tbl[r].e_cnt > 15) ? 15 : tbl[r].e_cnt);
    end

    idle_inputs();
    for (int i = 0; i < 20; i++) tick();
    chk("sat.cnt4", int'(cycle_cnt4), 15);
    chk("sat.cnt", int'(cycle_cnt), 22);
    check_model("sat");

    #2 reset = 1'b1;
    #1;
    chk("midrst.pc", int'(pc), 0);
    chk("midrst.flag", int'(flag_q), 0);
    chk("midrst.running", int'(running), 0);
    chk("midrst.cnt", int'(cycle_cnt), 0);
    chk("midrst.cnt4", int'(cycle_cnt4), 0);
    #2 reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    start = 1;
    tick();
    start = 0; br_ne = 1; lut_idx = 5;
    tick();
    chk("lutrst.pc", int'(pc), 0);
    check_model("lutrst");

    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 19) == 0);
      stall     = ($urandom_range(0, 5) == 0);
      halt_req  = ($urandom_range(0, 39) == 0);
      flag_we   = 1'($urandom);
      one_i     = 1'($urandom);
      sc_we     = 1'($urandom);
      sc_i      = 1'($urandom);
      br_t      = ($urandom_range(0, 2) == 0);
      br_ne     = ($urandom_range(0, 2) == 0);
      lut_idx   = 4'($urandom);
      lut_we    = ($urandom_range(0, 3) == 0);
      lut_waddr = 4'($urandom);
      lut_wdata = 10'($urandom);
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
